// File: rtl/mult_pkg.sv
// Shared definitions for the mult4x4 product accumulator.
//   PROD_W_DEF : default product width (mult4x4 P output)
//   state_t    : accumulator FSM states (ST_ACCUM, ST_HOLD)
//   cnt_width  : bits needed for a beat counter running 0..n-1
package mult_pkg;

  localparam int PROD_W_DEF = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Beat counter width; at least one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_accum.sv
// mult_accum: sums COUNT_N consecutive unsigned products from mult4x4 into one
// dot-product result and presents it over a valid/ready handshake.
//
// Optional feature macro: MAC_SAT_EN
//   defined   : on carry the result clamps to all ones for the rest of that result
//   undefined : the result wraps modulo 2^ACC_W (default build)
//   out_ovf is set on carry in both builds.
//
// Ports
//   clk       in   1       system clock, all state on posedge
//   rst       in   1       synchronous active-high reset
//   clr       in   1       discard the partial sum (ACCUM state only)
//   in_valid  in   1       in_prod valid
//   in_ready  out  1       block accepts in_prod this cycle
//   in_prod   in   PROD_W  product, unsigned
//   out_valid out  1       out_sum/out_ovf valid
//   out_ready in   1       consumer accepts result
//   out_sum   out  ACC_W   accumulated result, unsigned
//   out_ovf   out  1       result overflowed ACC_W bits
module mult_accum
  import mult_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = 10,
  parameter int COUNT_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int              CNT_W = cnt_width(COUNT_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_N - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_full;
  logic             carry;
  logic             ovf_nxt;
  logic [ACC_W-1:0] sum_nxt;
  logic             accept;

  // One extra bit on the adder captures the carry out of ACC_W bits.
  always_comb begin
    sum_full = {1'b0, acc} + (ACC_W + 1)'(in_prod);
    carry    = sum_full[ACC_W];
    ovf_nxt  = ovf | carry;
`ifdef MAC_SAT_EN
    // Once a result has overflowed it stays pinned at full scale.
    sum_nxt  = ovf_nxt ? '1 : sum_full[ACC_W-1:0];
`else
    sum_nxt  = sum_full[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_ACCUM: begin
        in_ready = ~clr;
        accept   = in_valid & ~clr;
        if (accept && cnt == LAST) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_ACCUM;
      end
      default: state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_ACCUM) begin
        if (clr) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end else if (accept) begin
          if (cnt == LAST) begin
            out_sum <= sum_nxt;
            out_ovf <= ovf_nxt;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
          end else begin
            acc <= sum_nxt;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// Testbench for mult_accum. Two instances share one stimulus stream: the
// default configuration (ACC_W=10) and a narrow one (ACC_W=9) whose results
// overflow readily. Expected results are derived from the plain arithmetic
// total of each group of four accepted products.
module tb_mult_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_ovf_a;
  logic [9:0] out_sum_a;
  logic       in_ready_b, out_valid_b, out_ovf_b;
  logic [8:0] out_sum_b;

  mult_accum u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a)
  );

  mult_accum #(.PROD_W(8), .ACC_W(9), .COUNT_N(4)) u_dut9 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum_a;
    int ovf_a;
    int sum_b;
    int ovf_b;
  } exp_t;

  exp_t exp_q[$];
  int   part_total = 0;
  int   part_n     = 0;
  int   n_vec      = 0;
  int   n_err      = 0;
  int   ready_rand = 0;
  int   ready_val  = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fold(input int total, input int w);
    int lim = 1 << w;
    if (total < lim) return total;
`ifdef MAC_SAT_EN
    return lim - 1;
`else
    return total % lim;
`endif
  endfunction

  function automatic void note_accept(input int p);
    exp_t e;
    part_total += p;
    part_n++;
    if (part_n == 4) begin
      e.sum_a = fold(part_total, 10);
      e.ovf_a = (part_total >= 1024) ? 1 : 0;
      e.sum_b = fold(part_total, 9);
      e.ovf_b = (part_total >= 512) ? 1 : 0;
      exp_q.push_back(e);
      part_total = 0;
      part_n     = 0;
    end
  endfunction

  // out_ready is driven just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand != 0 ? 1'($urandom_range(0, 1)) : 1'(ready_val);
    end
  end

  // Monitor: checks each handed-off result against the scoreboard and
  // watches that a held result does not move while backpressured.
  initial begin
    bit  held = 0;
    int  held_sum = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 0;
      end else if (out_valid_a) begin
        chk("in_ready_in_hold", int'(in_ready_a), 0);
        if (held) chk("sum_stable", int'(out_sum_a), held_sum);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_sum", int'(out_sum_a), e.sum_a);
            chk("out_ovf", int'(out_ovf_a), e.ovf_a);
            chk("out_valid_w9", int'(out_valid_b), 1);
            chk("out_sum_w9", int'(out_sum_b), e.sum_b);
            chk("out_ovf_w9", int'(out_ovf_b), e.ovf_b);
          end
          held = 0;
        end else begin
          held     = 1;
          held_sum = int'(out_sum_a);
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic beat(input int p);
    int tries = 0;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b1;
    in_prod  = 8'(p);
    #1;
    while (!in_ready_a) begin
      tries++;
      if (tries > 100) begin
        chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    note_accept(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      in_prod  = 8'($urandom);
    end
  endtask

  // Asserts clr for one ACCUM cycle with a (to-be-ignored) valid beat present.
  task automatic clr_pulse();
    int tries = 0;
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    #1;
    while (out_valid_a) begin
      tries++;
      if (tries > 100) begin
        chk("clr_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      #1;
    end
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'($urandom);
    #1;
    chk("in_ready_clr", int'(in_ready_a), 0);
    @(posedge clk);
    part_total = 0;
    part_n     = 0;
  endtask

  task automatic drain();
    int tries = 0;
    while (exp_q.size() != 0 && tries < 300) begin
      idle(1);
      tries++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst      = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_prod  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_sum", int'(out_sum_a), 0);
    chk("rst_out_ovf", int'(out_ovf_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 1);
    rst = 1'b0;

    // Basic: 0,1,15,225 -> 241; valid exactly one cycle after the 4th beat.
    beat(0); beat(1); beat(15);
    #1;
    chk("pre_valid", int'(out_valid_a), 0);
    beat(225);
    #1;
    chk("latency_valid", int'(out_valid_a), 1);
    drain();

    // Reset mid-accumulation discards the partial sum.
    beat(100); beat(100);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    part_total = 0;
    part_n     = 0;
    #1;
    chk("post_rst_valid", int'(out_valid_a), 0);
    chk("post_rst_ready", int'(in_ready_a), 1);
    beat(10); beat(20); beat(30); beat(40);
    drain();

    // Backpressure: result held for 5 cycles.
    ready_val = 0;
    @(posedge clk);
    beat(7); beat(8); beat(9); beat(10);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_valid", int'(out_valid_a), 1);
      chk("bp_in_ready", int'(in_ready_a), 0);
    end
    ready_val = 1;
    drain();

    // Gaps between beats do not count.
    for (int i = 0; i < 4; i++) begin
      beat(60);
      idle(1);
    end
    drain();

    // clr discards two beats of 225.
    beat(225); beat(225);
    clr_pulse();
    beat(15); beat(15); beat(15); beat(15);
    drain();

    // 4x225 = 900 overflows 9 bits; the following result starts clean.
    beat(225); beat(225); beat(225); beat(225);
    beat(1); beat(2); beat(3); beat(4);
    drain();

    // Randomized traffic with random backpressure, gaps and clears.
    ready_rand = 1;
    for (int i = 0; i < 200; i++) begin
      int r = int'($urandom_range(0, 9));
      if (r == 0) clr_pulse();
      else if (r < 3) idle(int'($urandom_range(1, 3)));
      else beat(int'($urandom_range(0, 15)) * int'($urandom_range(0, 15)));
    end
    ready_rand = 0;
    ready_val  = 1;
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
